// File: rtl/multi_tick_gen_if.sv
// Config write channel for multi_tick_gen.
// Carries the valid/ready handshake, channel index, divisor and mode.
interface multi_tick_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 26,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_oneshot;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_oneshot,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_oneshot,
    output cfg_ready
  );
endinterface

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator.
// Periodic or one-shot single-cycle enables with shadowed divisors.
module multi_tick_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 26,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  multi_tick_gen_if.slave   cfg,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] armed
);

  localparam int CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_W-1:0] DEF_DIV =
    DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE =
    DIV_W'(1);

  logic [NUM_CH-1:0] pending;

  // Out-of-range channel indices are accepted and dropped.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i))
        cfg.cfg_ready = !pending[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] sh_div_q;
    logic             os_q;
    logic             sh_os_q;
    logic             pend_q;
    logic             tick_q;
    logic             armed_q;
    logic             acc;
    logic             run;
    logic             tc;
    logic             direct;
    logic             sh_ld;

    always_comb begin
      acc = cfg.cfg_valid & cfg.cfg_ready &
            (cfg.cfg_ch == CH_W'(g));
      run = ch_en[g] & (div_q != '0) &
            !(os_q & !armed_q);
      tc  = run & (cnt_q == div_q - ONE);
      // Anything not mid-period takes the write at once.
      direct = acc & (!run | sync | tc);
      sh_ld  = pend_q & (!ch_en[g] | sync | tc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        div_q    <= DEF_DIV;
        os_q     <= 1'b0;
        sh_div_q <= '0;
        sh_os_q  <= 1'b0;
        pend_q   <= 1'b0;
        tick_q   <= 1'b0;
        armed_q  <= 1'b1;
      end else begin
        tick_q <= tc;
        if (run & !sync & !tc)
          cnt_q <= cnt_q + ONE;
        else
          cnt_q <= '0;

        if (direct) begin
          div_q <= cfg.cfg_div;
          os_q  <= cfg.cfg_oneshot;
        end else if (sh_ld) begin
          div_q <= sh_div_q;
          os_q  <= sh_os_q;
        end

        if (acc & !direct) begin
          sh_div_q <= cfg.cfg_div;
          sh_os_q  <= cfg.cfg_oneshot;
          pend_q   <= 1'b1;
        end else if (sh_ld) begin
          pend_q   <= 1'b0;
        end

        if (!ch_en[g] | sync | direct | sh_ld)
          armed_q <= 1'b1;
        else if (tc & os_q)
          armed_q <= 1'b0;
      end
    end

    assign pending[g] = pend_q;
    assign tick[g]    = tick_q;
    assign armed[g]   = armed_q;
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen.
// NUM_CH=2, DIV_W=8, DEFAULT_DIV=4.
module tb_multi_tick_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ch_en;
  logic       sync;
  logic [1:0] tick;
  logic [1:0] armed;

  int errors = 0;
  int checks = 0;

  multi_tick_gen_if #(.NUM_CH(2), .DIV_W(8)) cfg ();

  multi_tick_gen #(
    .NUM_CH(2),
    .DIV_W(8),
    .DEFAULT_DIV(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ch_en (ch_en),
    .sync  (sync),
    .cfg   (cfg),
    .tick  (tick),
    .armed (armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic       ch,
                        input logic [7:0] d,
                        input logic       os);
    cfg.cfg_valid   = 1'b1;
    cfg.cfg_ch      = ch;
    cfg.cfg_div     = d;
    cfg.cfg_oneshot = os;
    step();
    cfg.cfg_valid   = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    ch_en           = 2'b00;
    sync            = 1'b0;
    cfg.cfg_valid   = 1'b0;
    cfg.cfg_ch      = 1'b0;
    cfg.cfg_div     = 8'd0;
    cfg.cfg_oneshot = 1'b0;
    step();
    step();
    chk("rst_tick", 32'(tick), 0);
    chk("rst_armed", 32'(armed), 3);
    chk("rst_ready", 32'(cfg.cfg_ready), 1);
    rst_n = 1'b1;

    // Default div=4 on ch0 only
    ch_en = 2'b01;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("def_tick", 32'(tick), (i % 4 == 0) ? 1 : 0);
    end
    chk("def_armed", 32'(armed), 3);

    // Shadowed write of div=3 at count 1
    step();
    cfg.cfg_valid   = 1'b1;
    cfg.cfg_ch      = 1'b0;
    cfg.cfg_div     = 8'd3;
    cfg.cfg_oneshot = 1'b0;
    #1;
    chk("sh_ready_pre", 32'(cfg.cfg_ready), 1);
    step();
    cfg.cfg_valid = 1'b0;
    #1;
    chk("sh_ready_pend", 32'(cfg.cfg_ready), 0);
    cfg.cfg_ch = 1'b1;
    #1;
    chk("sh_ready_ch1", 32'(cfg.cfg_ready), 1);
    cfg.cfg_ch = 1'b0;
    step();
    chk("sh_tick_mid", 32'(tick), 0);
    chk("sh_ready_mid", 32'(cfg.cfg_ready), 0);
    step();
    chk("sh_tick_end", 32'(tick), 1);
    chk("sh_ready_end", 32'(cfg.cfg_ready), 1);
    for (int j = 1; j <= 6; j++) begin
      step();
      chk("div3_tick", 32'(tick), (j % 3 == 0) ? 1 : 0);
    end

    // One-shot on ch1, div=5
    cfg_wr(1'b1, 8'd5, 1'b1);
    ch_en = 2'b10;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("os_tick", 32'(tick[1]), (j == 5) ? 1 : 0);
      chk("os_armed", 32'(armed[1]), (j < 5) ? 1 : 0);
    end
    ch_en = 2'b00;
    step();
    chk("os_rearm", 32'(armed[1]), 1);
    ch_en = 2'b10;
    for (int j = 1; j <= 7; j++) begin
      step();
      chk("os_refire", 32'(tick[1]), (j == 5) ? 1 : 0);
    end

    // sync aligns div=6 and div=3
    ch_en = 2'b00;
    step();
    cfg_wr(1'b0, 8'd6, 1'b0);
    cfg_wr(1'b1, 8'd3, 1'b0);
    ch_en = 2'b11;
    for (int j = 0; j < 4; j++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_tick0", 32'(tick), 0);
    for (int j = 1; j <= 6; j++) begin
      step();
      chk("sync_tick", 32'(tick),
          ((j % 3 == 0) ? 2 : 0) | ((j == 6) ? 1 : 0));
    end

    // div=1 and div=0 on disabled channels
    ch_en = 2'b00;
    step();
    cfg_wr(1'b0, 8'd1, 1'b0);
    cfg_wr(1'b1, 8'd0, 1'b0);
    ch_en = 2'b11;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("div1_div0", 32'(tick), 1);
    end

    // Async reset drops a high tick at once
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_tick", 32'(tick), 0);
    step();
    rst_n = 1'b1;
    ch_en = 2'b01;

    // Reset with a pending write restores div=4
    step();
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 1'b0;
    cfg.cfg_div   = 8'd2;
    step();
    cfg.cfg_valid = 1'b0;
    #1;
    chk("rp_pend", 32'(cfg.cfg_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rp_ready", 32'(cfg.cfg_ready), 1);
    chk("rp_tick", 32'(tick), 0);
    step();
    rst_n = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("rp_div4", 32'(tick), (j % 4 == 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
